// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 4-digit common-anode 7-segment scanner with prescaler, LZ blanking and guard.
// nibble/an are registered from pre-edge state, so they trail digit_idx by one clock.
module seg_scan_mux #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 16,
    parameter int GUARD   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       nibble_q, nibble_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q, tick_d;

    logic             slot_end;
    logic             in_guard;
    logic [3:0]       upper_zero;
    logic             dark;

    assign slot_end = (cnt_q == CNT_W'(CLK_DIV - 1));

    // The first presentation of a slot follows the edge where cnt is still 0..GUARD-1.
    if (GUARD > 0) begin : g_guard
        assign in_guard = (cnt_q < CNT_W'(GUARD));
    end else begin : g_no_guard
        assign in_guard = 1'b0;
    end

    // Bit k set when digits k..3 are all zero; digit0 is never blanked.
    assign upper_zero = {disp_q[15:12] == 4'h0,
                         disp_q[15:8]  == 8'h00,
                         disp_q[15:4]  == 12'h000,
                         1'b0};

    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        tick_d   = slot_end;
        disp_d   = load ? data_in : disp_q;
        dark     = ~digit_en[idx_q] | (lz_blank & upper_zero[idx_q]) | in_guard;
        nibble_d = disp_q[{idx_q, 2'b00} +: 4];
        an_d     = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            disp_q   <= 16'h0000;
            nibble_q <= 4'h0;
            an_q     <= 4'b1111;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            nibble_q <= nibble_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign nibble    = nibble_q;
    assign an        = an_q;
    assign digit_idx = idx_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized self-checking bench for seg_scan_mux against a slot-arithmetic model.
module tb_seg_scan_mux;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  digit_en;
    logic        lz_blank;

    logic [3:0]  nib0, an0, nib1, an1;
    logic [1:0]  idx0, idx1;
    logic        tick0, tick1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    logic [15:0] m_disp;

    always #5 clk = ~clk;

    seg_scan_mux #(.CLK_DIV(CLK_DIV), .CNT_W(4), .GUARD(0)) u_g0 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .nibble(nib0), .an(an0), .digit_idx(idx0), .tick(tick0)
    );

    seg_scan_mux #(.CLK_DIV(CLK_DIV), .CNT_W(4), .GUARD(1)) u_g1 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .nibble(nib1), .an(an1), .digit_idx(idx1), .tick(tick1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_an(int idx, int cnt, int guard, logic [3:0] en,
                                            logic lz, logic [15:0] d);
        bit         dark;
        logic [3:0] one_hot;
        dark = (en[idx] == 1'b0);
        if (lz && idx > 0 && (d >> (4 * idx)) == 16'h0) dark = 1'b1;
        if (cnt < guard) dark = 1'b1;
        one_hot = 4'b0001 << idx;
        return dark ? 4'b1111 : ~one_hot;
    endfunction

    // n counts non-reset edges since the last reset; slot position follows by division.
    task automatic step();
        int         cnt, idx;
        logic [3:0] e_nib, e_an0, e_an1;
        logic       e_tick;
        logic [1:0] e_idx;
        @(posedge clk);
        if (rst) begin
            n = 0; m_disp = 16'h0;
            e_nib = 4'h0; e_an0 = 4'hF; e_an1 = 4'hF; e_tick = 1'b0; e_idx = 2'd0;
        end else begin
            cnt    = n % CLK_DIV;
            idx    = (n / CLK_DIV) % 4;
            e_nib  = m_disp[4*idx +: 4];
            e_an0  = model_an(idx, cnt, 0, digit_en, lz_blank, m_disp);
            e_an1  = model_an(idx, cnt, 1, digit_en, lz_blank, m_disp);
            e_tick = (cnt == CLK_DIV - 1);
            n++;
            e_idx  = 2'((n / CLK_DIV) % 4);
            if (load) m_disp = data_in;
        end
        #1;
        chk("g0_idx", 16'(idx0), 16'(e_idx));
        chk("g0_tick", 16'(tick0), 16'(e_tick));
        chk("g0_nibble", 16'(nib0), 16'(e_nib));
        chk("g0_an", 16'(an0), 16'(e_an0));
        chk("g1_idx", 16'(idx1), 16'(e_idx));
        chk("g1_tick", 16'(tick1), 16'(e_tick));
        chk("g1_nibble", 16'(nib1), 16'(e_nib));
        chk("g1_an", 16'(an1), 16'(e_an1));
    endtask

    task automatic load_val(input logic [15:0] v);
        data_in = v; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        n = 0; m_disp = 16'h0;
        rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; digit_en = 4'hF; lz_blank = 1'b0;
        repeat (3) step();
        rst = 1'b0; load = 1'b0;
        repeat (8) step();

        load_val(16'h1234);
        repeat (20) step();

        lz_blank = 1'b1;
        load_val(16'h0050);
        repeat (16) step();
        load_val(16'h0000);
        repeat (16) step();

        lz_blank = 1'b0; digit_en = 4'b1010;
        load_val(16'h1234);
        repeat (16) step();

        digit_en = 4'hF;
        repeat (16) step();

        for (int k = 0; k < 16 && !((n % CLK_DIV) == CLK_DIV - 1 && ((n / CLK_DIV) % 4) == 0); k++)
            step();
        load_val(16'hABCD);
        repeat (6) step();
        for (int k = 0; k < 16 && ((n / CLK_DIV) % 4) != 2; k++)
            step();
        rst = 1'b1; load = 1'b1; data_in = 16'h5A5A;
        step();
        rst = 1'b0; load = 1'b0;
        repeat (8) step();

        for (int k = 0; k < 600; k++) begin
            load     = ($urandom % 8) == 0;
            data_in  = ($urandom % 4 == 0) ? 16'($urandom % 256) : 16'($urandom);
            lz_blank = 1'($urandom);
            if ($urandom % 16 == 0) digit_en = 4'($urandom);
            rst      = ($urandom % 97) == 0;
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
